// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit: tracks in-flight destination tags per
// downstream stage, forwards from the youngest ready producer and stalls on load-use.
module fwd_hazard_unit #(
    parameter int DATA_W     = 64,
    parameter int REG_W      = 5,
    parameter int ZERO_REG   = 31,
    parameter int NUM_SRC    = 2,
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 1,
    parameter int CNT_W      = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        issue_valid,
    input  logic                        issue_regwrite,
    input  logic                        issue_is_load,
    input  logic [REG_W-1:0]            issue_dest,
    input  logic [NUM_SRC*REG_W-1:0]    src_reg,
    input  logic [NUM_SRC-1:0]          src_used,
    input  logic [DEPTH*DATA_W-1:0]     stage_data,
    input  logic                        flush,
    input  logic                        stall_cnt_clr,
    output logic [NUM_SRC-1:0]          fwd,
    output logic [NUM_SRC*DATA_W-1:0]   fwd_data,
    output logic                        stall,
    output logic [CNT_W-1:0]            stall_count
);

    localparam logic [REG_W-1:0] ZeroReg = REG_W'(ZERO_REG);

    logic [DEPTH-1:0]            tagValid_q, tagValid_d;
    logic [DEPTH-1:0][REG_W-1:0] tagDest_q,  tagDest_d;
    logic [DEPTH-1:0]            tagLoad_q,  tagLoad_d;
    logic [CNT_W-1:0]            stallCnt_q, stallCnt_d;
    logic [NUM_SRC-1:0]          hazard;

    // Per operand, the first matching entry from stage 0 upward is the youngest
    // producer; older matches are shadowed even when the youngest is not ready.
    always_comb begin
        logic             found;
        logic [REG_W-1:0] src;
        fwd      = '0;
        fwd_data = '0;
        hazard   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            found = 1'b0;
            src   = src_reg[i*REG_W +: REG_W];
            if (src_used[i] && (src != ZeroReg)) begin
                for (int k = 0; k < DEPTH; k++) begin
                    if (!found && tagValid_q[k] && (tagDest_q[k] == src)) begin
                        found = 1'b1;
                        if (!tagLoad_q[k] || (k >= LOAD_READY)) begin
                            fwd[i]                       = 1'b1;
                            fwd_data[i*DATA_W +: DATA_W] = stage_data[k*DATA_W +: DATA_W];
                        end else begin
                            hazard[i] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign stall = issue_valid & (|hazard);

    // A stalled cycle pushes a bubble into stage 0 while older entries keep advancing.
    always_comb begin
        tagValid_d = tagValid_q;
        tagDest_d  = tagDest_q;
        tagLoad_d  = tagLoad_q;
        if (flush) begin
            tagValid_d = '0;
        end else begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                tagValid_d[k] = tagValid_q[k-1];
                tagDest_d[k]  = tagDest_q[k-1];
                tagLoad_d[k]  = tagLoad_q[k-1];
            end
            tagValid_d[0] = ~stall & issue_valid & issue_regwrite & (issue_dest != ZeroReg);
            tagDest_d[0]  = issue_dest;
            tagLoad_d[0]  = issue_is_load;
        end
    end

    always_comb begin
        stallCnt_d = stallCnt_q;
        if (stall_cnt_clr) begin
            stallCnt_d = '0;
        end else if (stall && (stallCnt_q != {CNT_W{1'b1}})) begin
            stallCnt_d = stallCnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tagValid_q <= '0;
            tagDest_q  <= '0;
            tagLoad_q  <= '0;
            stallCnt_q <= '0;
        end else begin
            tagValid_q <= tagValid_d;
            tagDest_q  <= tagDest_d;
            tagLoad_q  <= tagLoad_d;
            stallCnt_q <= stallCnt_d;
        end
    end

    assign stall_count = stallCnt_q;

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
Parametrised forwarding and load-use hazard unit for the pipelined datapath. It supersedes the fixed two-source, two-stage forwarding logic. The block keeps its own shift pipeline of in-flight destination tags, one entry per downstream stage. For every decode-stage source operand it selects the youngest ready producer, and it raises a stall when the youngest matching producer is a load whose data is not yet available. A saturating stall counter is kept for performance measurement.

Parameters:
DATA_W, 64, width of forwarded data
REG_W, 5, register index width
ZERO_REG, 31, hard-wired zero register index; never forwarded, never causes a hazard
NUM_SRC, 2, number of decode-stage source operands
DEPTH, 3, number of tracked producer stages (stage 0 = EX output, increasing toward WB)
LOAD_READY, 1, lowest stage index at which load result data is valid (0 <= LOAD_READY < DEPTH)
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, all state updates on rising edge
reset_n  in  1  asynchronous active-low reset
issue_valid  in  1  decode-stage instruction valid this cycle
issue_regwrite  in  1  decode instruction writes a register
issue_is_load  in  1  decode instruction is a load
issue_dest  in  REG_W  decode instruction destination register
src_reg  in  NUM_SRC*REG_W  source register indices, operand i at bits [i*REG_W +: REG_W]
src_used  in  NUM_SRC  operand i is actually read
stage_data  in  DEPTH*DATA_W  result data present at each producer stage, stage k at [k*DATA_W +: DATA_W]
flush  in  1  squash all in-flight tags (branch mispredict)
stall_cnt_clr  in  1  synchronous clear of stall counter
fwd  out  NUM_SRC  operand i takes forwarded data instead of register file
fwd_data  out  NUM_SRC*DATA_W  forwarded value per operand
stall  out  1  hold decode and fetch; bubble is inserted into stage 0
stall_count  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Tag entry k holds {v, dest, is_load}. On reset: all v=0 and stall_count=0. Consequently fwd=0, fwd_data=0 and stall=0 while reset_n=0.
- Tag pipeline update on each rising edge, in priority order:
  - flush=1: all v<=0. Flush has priority over stall and issue.
  - else stall=1: entry 0 <= bubble (v=0), entries k <= k-1 for k>=1.
  - else: entry 0 <= {issue_valid & issue_regwrite & (issue_dest!=ZERO_REG), issue_dest, issue_is_load}, entries k <= k-1 for k>=1.
  - Entry DEPTH-1 is discarded on shift.
- Forwarding is combinational, per operand i:
  - If src_used[i]=0 or src_reg[i]==ZERO_REG: fwd[i]=0, fwd_data[i]=0, no hazard.
  - Otherwise scan k=0..DEPTH-1 and take the first (youngest) entry with v=1 and dest==src_reg[i].
    - If it is not a load, or k>=LOAD_READY: fwd[i]=1, fwd_data[i]=stage_data[k].
    - Otherwise: hazard[i]=1, fwd[i]=0, fwd_data[i]=0.
  - No match: fwd[i]=0, fwd_data[i]=0.
  - Older matches are ignored whenever a younger match exists, even if that younger match is not ready.
- stall = issue_valid & |hazard. This is combinational with zero-cycle latency.
- A load in stage 0 consumed next: exactly LOAD_READY stall cycles, after which data forwards from stage LOAD_READY.
- stall_count, evaluated on each edge:
  - stall_cnt_clr=1: <=0. Clear wins over increment.
  - else stall=1 and stall_count != all-ones: +1.
  - Saturates at 2^CNT_W-1. Unaffected by flush.
- Reset asserted mid-operation clears tags and counter immediately (asynchronous). No forwarding or stall follows reset deassertion until new issues enter the pipeline.

Test Plan:
- Reset: hold reset_n=0 with src_reg={3,3} and pre-reset tags valid for X3 -> fwd=00, stall=0, stall_count=0. Deassert reset -> still fwd=00.
- ALU chain: issue ADD X5 (regwrite, not load). Next cycle src_reg[0]=5, stage_data[0]=64'hDEAD_BEEF -> fwd[0]=1, fwd_data[0]=64'hDEAD_BEEF, stall=0. One cycle later the match moves to stage 1.
- Youngest wins: X7 writes in stage 0 (data 0x11) and in stage 2 (data 0x22). src_reg[1]=7 -> fwd[1]=1, fwd_data[1]=0x11.
- Load-use: issue LDUR X9. Next cycle src_reg[0]=9 -> stall=1 for exactly 1 cycle, stall_count=1. Following cycle: fwd[0]=1, fwd_data[0]=stage_data[1]=0xCAFE, stall=0.
- Zero register and flush: an issue with dest=31 followed by src=31 -> fwd=0, stall=0. A load X4 in stage 0 plus flush=1 -> next cycle src=4 gives fwd=0, stall=0.
- Counter: force continuous stall for 2^16+5 cycles -> stall_count=16'hFFFF. Assert stall_cnt_clr together with stall -> next value 0.
